// File: rtl/binary_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : binary_round_ctrl
//  Brief    : Target generation, round timing and scoring for the binary game.
//  Revision : 1.0
// ============================================================================

module binary_round_ctrl #(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int ROUND_SECS    = 10,
    parameter int ROUNDS        = 10
) (
    input  logic       board_clk,
    input  logic       Reset_Pulse,
    input  logic       start,
    input  logic       submit,
    input  logic       quit,
    input  logic [7:0] userNumber,
    output logic [7:0] outputNumber,
    output logic [7:0] playerScore,
    output logic [3:0] timeLeft,
    output logic [3:0] roundNum,
    output logic       busy,
    output logic       done,
    output logic       hit,
    output logic       miss
);

    localparam int                    c_TICK_W     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [c_TICK_W-1:0]   c_TICK_MAX   = c_TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [3:0]            c_ROUND_SECS = 4'(ROUND_SECS);
    localparam logic [3:0]            c_ROUNDS     = 4'(ROUNDS);
    localparam logic [7:0]            c_SEED       = 8'h5A;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_lfsr;
    logic [7:0]            r_target;
    logic [7:0]            r_score;
    logic [3:0]            r_time_left;
    logic [3:0]            r_round;
    logic [c_TICK_W-1:0]   r_tick;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_hit;
    logic                  r_miss;

    logic                  w_wrap;
    logic                  w_new_game;
    logic                  w_latch;
    logic                  w_hit;
    logic                  w_miss;
    logic                  w_round_inc;
    logic                  w_tick_run;

    assign w_wrap = (r_tick == c_TICK_MAX);

    always_ff @(posedge board_clk or posedge Reset_Pulse) begin
        if (Reset_Pulse) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_new_game  = 1'b0;
        w_latch     = 1'b0;
        w_hit       = 1'b0;
        w_miss      = 1'b0;
        w_round_inc = 1'b0;
        w_tick_run  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_new_game  = 1'b1;
                end
            end
            S_LOAD: begin
                if (quit) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                    w_latch     = 1'b1;
                end
            end
            S_RUN: begin
                if (quit) begin
                    w_state_nxt = S_DONE;
                end else if (submit || (w_wrap && r_time_left == 4'd1)) begin
                    // A submit on the timeout edge is judged as a submit only.
                    if (submit) begin
                        w_hit  = (userNumber == r_target);
                        w_miss = (userNumber != r_target);
                    end else begin
                        w_miss     = 1'b1;
                        w_tick_run = 1'b1;
                    end
                    if (r_round == c_ROUNDS) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_LOAD;
                        w_round_inc = 1'b1;
                    end
                end else begin
                    w_tick_run = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_new_game  = 1'b1;
                end else if (quit) begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge board_clk or posedge Reset_Pulse) begin
        if (Reset_Pulse) begin
            r_lfsr      <= c_SEED;
            r_target    <= 8'd0;
            r_score     <= 8'd0;
            r_time_left <= 4'd0;
            r_round     <= 4'd0;
            r_tick      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_hit       <= 1'b0;
            r_miss      <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            r_hit  <= w_hit;
            r_miss <= w_miss;
            r_busy <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN);
            r_done <= (w_state_nxt == S_DONE);

            if (w_new_game) begin
                r_score <= 8'd0;
                r_round <= 4'd1;
            end else if (w_round_inc) begin
                r_round <= r_round + 4'd1;
            end

            if (w_hit && r_score != 8'hFF) begin
                r_score <= r_score + 8'd1;
            end

            if (w_latch) begin
                r_target    <= r_lfsr;
                r_time_left <= c_ROUND_SECS;
                r_tick      <= '0;
            end else if (w_tick_run) begin
                if (w_wrap) begin
                    r_tick      <= '0;
                    r_time_left <= r_time_left - 4'd1;
                end else begin
                    r_tick <= r_tick + c_TICK_W'(1);
                end
            end
        end
    end

    assign outputNumber = r_target;
    assign playerScore  = r_score;
    assign timeLeft     = r_time_left;
    assign roundNum     = r_round;
    assign busy         = r_busy;
    assign done         = r_done;
    assign hit          = r_hit;
    assign miss         = r_miss;

endmodule

`default_nettype wire
